// File: rtl/scan_note_pkg.sv
// Shared constants and prefix-state type for the PS/2 scan-code note mapper.
package scan_note_pkg;

  localparam logic [7:0] EXT_CODE    = 8'hE0;
  localparam logic [7:0] BREAK_CODE  = 8'hF0;
  localparam logic [7:0] ERR_CODE_00 = 8'h00;
  localparam logic [7:0] ERR_CODE_FF = 8'hFF;
  localparam logic [7:0] ERR_CODE_E1 = 8'hE1;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } prefix_state_e;

  // Error/pause codes abort any prefix sequence without touching notes.
  function automatic logic is_ignore_code(input logic [7:0] code);
    return (code == ERR_CODE_00) || (code == ERR_CODE_FF) || (code == ERR_CODE_E1);
  endfunction

endpackage

// File: rtl/scan_note_mapper_if.sv
// Scan-code input strobe plus note-event output stream of the mapper.
interface scan_note_mapper_if #(
  parameter int unsigned NUM_NOTES = 8
) ();
  localparam int unsigned IdxW = $clog2(NUM_NOTES);

  logic [7:0]      scan_code;
  logic            scan_valid;
  logic            ev_valid;
  logic            ev_ready;
  logic [IdxW-1:0] ev_index;
  logic            ev_press;

  modport master (
    output scan_code, scan_valid, ev_ready,
    input  ev_valid, ev_index, ev_press
  );

  modport slave (
    input  scan_code, scan_valid, ev_ready,
    output ev_valid, ev_index, ev_press
  );
endinterface

// File: rtl/note_event_fifo.sv
// First-word-fall-through FIFO; head reads zero while empty.
module note_event_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             pop_eff, push_acc;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  // Pop on empty is ignored; a full FIFO still takes a push when it pops.
  assign pop_eff  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_eff);
  assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/scan_note_mapper.sv
// Decodes PS/2 make/break sequences into a held-note bitmap and a press/release event stream.
module scan_note_mapper
  import scan_note_pkg::*;
#(
  parameter int unsigned NUM_NOTES  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_NOTES-1:0] pattern_flat,
  input  logic [NUM_NOTES-1:0]   ext_mask,
  output logic [NUM_NOTES-1:0]   note,
  output logic                   overflow,
  scan_note_mapper_if.slave      bus
);
  localparam int unsigned IdxW = $clog2(NUM_NOTES);
  localparam int unsigned EvW  = IdxW + 1;

  prefix_state_e        state_q, state_d;
  logic [NUM_NOTES-1:0] note_q, note_d;
  logic                 overflow_q, overflow_d;

  logic            resolve, ext_flag, brk_flag;
  logic            hit;
  logic [IdxW-1:0] hit_idx;
  logic            push;
  logic [EvW-1:0]  push_data, head;
  logic            fifo_full, fifo_empty;

  always_comb begin
    state_d  = state_q;
    resolve  = 1'b0;
    ext_flag = 1'b0;
    brk_flag = 1'b0;
    if (bus.scan_valid) begin
      if (is_ignore_code(bus.scan_code)) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.scan_code == EXT_CODE)        state_d = StExt;
            else if (bus.scan_code == BREAK_CODE) state_d = StBrk;
            else                                  resolve = 1'b1;
          end
          StExt: begin
            if (bus.scan_code == BREAK_CODE) begin
              state_d = StExtBrk;
            end else if (bus.scan_code != EXT_CODE) begin
              resolve  = 1'b1;
              ext_flag = 1'b1;
              state_d  = StIdle;
            end
          end
          StBrk: begin
            if (bus.scan_code == EXT_CODE) begin
              state_d = StIdle;
            end else if (bus.scan_code != BREAK_CODE) begin
              resolve  = 1'b1;
              brk_flag = 1'b1;
              state_d  = StIdle;
            end
          end
          StExtBrk: begin
            state_d = StIdle;
            if (bus.scan_code != EXT_CODE && bus.scan_code != BREAK_CODE) begin
              resolve  = 1'b1;
              ext_flag = 1'b1;
              brk_flag = 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_NOTES) - 1; i >= 0; i--) begin
      if (pattern_flat[8*i +: 8] == bus.scan_code && ext_mask[i] == ext_flag) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    note_d     = note_q;
    push       = 1'b0;
    push_data  = {hit_idx, !brk_flag};
    overflow_d = overflow_q;
    if (resolve && hit) begin
      if (brk_flag && note_q[hit_idx]) begin
        note_d[hit_idx] = 1'b0;
        push            = 1'b1;
      end else if (!brk_flag && !note_q[hit_idx]) begin
        note_d[hit_idx] = 1'b1;
        push            = 1'b1;
      end
    end
    if (push && fifo_full && !bus.ev_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      note_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      overflow_q <= overflow_d;
    end
  end

  note_event_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EvW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (bus.ev_ready),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign note         = note_q;
  assign overflow     = overflow_q;
  assign bus.ev_valid = !fifo_empty;
  assign bus.ev_index = head[EvW-1:1];
  assign bus.ev_press = head[0];

endmodule
